// File: rtl/letc_core_pkg.sv
// Core-level types for the execute-to-memory boundary.
package letc_core_pkg;

  typedef enum logic [1:0] {
    MEMOP_NONE  = 2'd0,
    MEMOP_LOAD  = 2'd1,
    MEMOP_STORE = 2'd2
  } memop_e;

  typedef struct packed {
    letc_pkg::word_t    alu_result;
    riscv_pkg::reg_idx_t rd_idx;
    logic               rd_we;
    memop_e             memop;
    letc_pkg::word_t    store_data;
  } e2m_entry_s;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } e2m_state_e;

  // A result can be forwarded once it writes a real register and is not still waiting on memory.
  function automatic logic fwd_eligible(input e2m_entry_s e);
    return e.rd_we & (e.rd_idx != '0) & (e.memop != MEMOP_LOAD);
  endfunction

endpackage

// File: rtl/letc_pkg.sv
// Shared LETC machine types.
package letc_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/riscv_pkg.sv
// RISC-V architectural types.
package riscv_pkg;

  localparam int unsigned REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/letc_core_e2m_entry_reg.sv
// One E2M payload register with clear-over-load priority.
module letc_core_e2m_entry_reg
  import letc_core_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic       i_clear,
  input  e2m_entry_s i_d,
  output e2m_entry_s o_q
);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_q <= '0;
    end else if (i_clear) begin
      o_q <= '0;
    end else if (i_load) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/letc_core_e2m_skid.sv
// Two-entry skid buffer between execute and memory with head forwarding
// and a saturating back-pressure counter.
module letc_core_e2m_skid
  import letc_pkg::*;
  import riscv_pkg::*;
  import letc_core_pkg::*;
#(
  parameter bit          CLEAR_ON_FLUSH = 1'b1,
  parameter int unsigned STALL_CTR_W    = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_e_valid,
  output logic                   o_e_ready,
  input  word_t                  i_e_alu_result,
  input  reg_idx_t               i_e_rd_idx,
  input  logic                   i_e_rd_we,
  input  memop_e                 i_e_memop,
  input  word_t                  i_e_store_data,
  output logic                   o_m_valid,
  input  logic                   i_m_ready,
  output word_t                  o_m_alu_result,
  output reg_idx_t               o_m_rd_idx,
  output logic                   o_m_rd_we,
  output memop_e                 o_m_memop,
  output word_t                  o_m_store_data,
  input  logic                   i_flush,
  output logic                   o_fwd_valid,
  output reg_idx_t               o_fwd_rd_idx,
  output word_t                  o_fwd_value,
  output logic [STALL_CTR_W-1:0] o_stall_cycles
);

  e2m_state_e state_q, state_d;
  e2m_entry_s in_entry, main_d, main_q, skid_q;
  logic       push, pop;
  logic       main_load, main_from_skid, skid_load, clear_payload;
  logic       fwd_valid_d;

  assign in_entry = '{alu_result: i_e_alu_result, rd_idx: i_e_rd_idx, rd_we: i_e_rd_we,
                      memop: i_e_memop, store_data: i_e_store_data};

  assign push = i_e_valid & o_e_ready;
  assign pop  = o_m_valid & i_m_ready;

  // State register plus registered handshake/forward flags derived from the next state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_EMPTY;
      o_e_ready   <= 1'b1;
      o_m_valid   <= 1'b0;
      o_fwd_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      o_e_ready   <= (state_d != ST_TWO);
      o_m_valid   <= (state_d != ST_EMPTY);
      o_fwd_valid <= fwd_valid_d;
    end
  end

  // Next-state logic; flush overrides any handshake in the same cycle.
  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (push) state_d = ST_ONE;
        ST_ONE: begin
          if (push && !pop)      state_d = ST_TWO;
          else if (!push && pop) state_d = ST_EMPTY;
        end
        ST_TWO:   if (pop) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Register-file control for MAIN and SKID.
  always_comb begin
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    clear_payload  = i_flush & CLEAR_ON_FLUSH;
    if (!i_flush) begin
      case (state_q)
        ST_EMPTY: main_load = push;
        ST_ONE: begin
          main_load = push & pop;
          skid_load = push & !pop;
        end
        ST_TWO: begin
          main_load      = pop;
          main_from_skid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign main_d      = main_from_skid ? skid_q : in_entry;
  assign fwd_valid_d = (state_d != ST_EMPTY) & fwd_eligible(main_load ? main_d : main_q);

  letc_core_e2m_entry_reg u_main (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (main_load),
    .i_clear (clear_payload),
    .i_d     (main_d),
    .o_q     (main_q)
  );

  letc_core_e2m_entry_reg u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (skid_load),
    .i_clear (clear_payload),
    .i_d     (in_entry),
    .o_q     (skid_q)
  );

  // Counts cycles the execute stage is blocked; sticks at all-ones.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_stall_cycles <= '0;
    end else if (i_e_valid && !o_e_ready && !i_flush && (o_stall_cycles != '1)) begin
      o_stall_cycles <= o_stall_cycles + STALL_CTR_W'(1);
    end
  end

  assign o_m_alu_result = main_q.alu_result;
  assign o_m_rd_idx     = main_q.rd_idx;
  assign o_m_rd_we      = main_q.rd_we;
  assign o_m_memop      = main_q.memop;
  assign o_m_store_data = main_q.store_data;
  assign o_fwd_rd_idx   = main_q.rd_idx;
  assign o_fwd_value    = main_q.alu_result;

endmodule

// File: doc/letc_core_e2m_skid.md
LETC_CORE_E2M_SKID -- requirements
Module: letc_core_e2m_skid

Interface
REQ-001 SHALL have parameter CLEAR_ON_FLUSH, default 1, meaning a flush also zeroes the payload registers.
REQ-002 SHALL have parameter STALL_CTR_W, default 16, meaning the width of the stall-cycle counter.
REQ-003 SHALL have i_clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have i_rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have i_e_valid  in  1  execute stage offers an entry.
REQ-006 SHALL have o_e_ready  out  1  block can accept an entry.
REQ-007 SHALL have i_e_alu_result  in  word_t (32)  ALU result.
REQ-008 SHALL have i_e_rd_idx  in  reg_idx_t (5)  destination register.
REQ-009 SHALL have i_e_rd_we  in  1  destination write enable.
REQ-010 SHALL have i_e_memop  in  memop_e (2)  NONE/LOAD/STORE.
REQ-011 SHALL have i_e_store_data  in  word_t (32)  store data.
REQ-012 SHALL have o_m_valid  out  1  head entry presented to memory stage.
REQ-013 SHALL have i_m_ready  in  1  memory stage consumes the head entry.
REQ-014 SHALL have o_m_alu_result, o_m_rd_idx, o_m_rd_we, o_m_memop, o_m_store_data  out  as inputs  head entry payload.
REQ-015 SHALL have i_flush  in  1  synchronous pipeline flush.
REQ-016 SHALL have o_fwd_valid  out  1, o_fwd_rd_idx  out  5, o_fwd_value  out  32  forwarding of the head entry to the ALU operand mux.
REQ-017 SHALL have o_stall_cycles  out  STALL_CTR_W  saturating back-pressure counter.

Function
REQ-018 SHALL hold two entry registers, MAIN (head) and SKID, with states EMPTY, ONE (MAIN valid) and TWO (both valid).
REQ-019 SHALL define push = i_e_valid & o_e_ready and pop = o_m_valid & i_m_ready.
REQ-020 SHALL drive o_e_ready registered: 1 in EMPTY/ONE, 0 in TWO.
REQ-021 SHALL transition EMPTY+push -> ONE, with the entry visible on o_m_* the following cycle (1-cycle latency).
REQ-022 SHALL transition ONE+push+!pop -> TWO with the input captured in SKID, and ONE+push+pop -> ONE with the input replacing MAIN.
REQ-023 SHALL transition ONE+!push+pop -> EMPTY, and TWO+pop -> ONE with SKID moved into MAIN.
REQ-024 SHALL otherwise hold state; o_m_* SHALL remain bit-stable while o_m_valid & !i_m_ready.
REQ-025 SHALL preserve FIFO order; no entry is dropped or duplicated except by flush.
REQ-026 SHALL, on i_flush, go to EMPTY the next cycle and discard any same-cycle input; flush has priority over push and pop, and o_e_ready is 1 the cycle after.
REQ-027 SHALL zero the payload registers on flush when CLEAR_ON_FLUSH=1 and leave them unchanged when it is 0.
REQ-028 SHALL drive o_fwd_valid = o_m_valid & o_m_rd_we & (o_m_rd_idx != 0) & (o_m_memop != LOAD), with o_fwd_rd_idx = o_m_rd_idx and o_fwd_value = o_m_alu_result.
REQ-029 SHALL increment o_stall_cycles each cycle i_e_valid & !o_e_ready & !i_flush, saturating at all-ones without wrapping.

Reset
REQ-030 SHALL, while i_rst is high, force state EMPTY, o_m_valid=0, o_e_ready=1, all payload registers 0, o_stall_cycles=0, and o_fwd_valid=0.
REQ-031 SHALL apply reset asynchronously: an assertion mid-operation, including in TWO, SHALL discard both entries immediately.

Structure
REQ-032 SHALL place memop_e in letc_core_pkg, word_t in letc_pkg, and reg_idx_t in riscv_pkg.
REQ-033 SHALL use e2m_entry_s, a packed payload struct in letc_core_pkg, for MAIN and SKID.
REQ-034 SHALL implement the entry register as one sub-module, letc_core_e2m_entry_reg, instantiated twice.

Verification
REQ-035 SHALL cover push {alu=32'h00000003, rd=5, we=1, NONE} from EMPTY with i_m_ready=1 -> o_m_valid next cycle, o_fwd_valid=1, o_fwd_value=32'h00000003.
REQ-036 SHALL cover i_m_ready=0 with three pushes A, B, C -> A, B accepted, o_e_ready=0 from the third cycle, C held; then i_m_ready=1 -> outputs A, B, C in order.
REQ-037 SHALL cover TWO with i_flush=1, i_e_valid=1 -> next cycle o_m_valid=0, o_e_ready=1, payload=0, and the input is never output.
REQ-038 SHALL cover a LOAD with rd=7, we=1 -> o_fwd_valid=0; a push with rd=0, we=1 -> o_fwd_valid=0.
REQ-039 SHALL cover STALL_CTR_W=4 with 20 back-pressured cycles -> o_stall_cycles saturates at 4'hF.
REQ-040 SHALL cover i_rst asserted mid-TWO between clock edges -> o_m_valid=0 and o_stall_cycles=0 before the next edge.
